// File: rtl/data_mem_access_unit_if.sv
// Core-side request/response signals plus the data-memory port, bundled into one interface.
// No logic; pure wiring.
// The slave modport is the access unit's view, the master modport is the core+memory view.
interface data_mem_access_unit_if #(
  parameter int AW = 16,
  parameter int DW = 32,
  parameter int BW = 5
);
  // core request side
  logic          REQ;
  logic [1:0]    OP;
  logic [AW-1:0] ADDR;
  logic [BW-1:0] BIT_SEL;
  logic [DW-1:0] WDATA;
  // core response side
  logic          BUSY;
  logic          DONE;
  logic          ERR;
  logic [DW-1:0] RDATA;
  // data memory port
  logic          M_WE;
  logic [AW-1:0] M_A;
  logic [DW-1:0] M_DI;
  logic [DW-1:0] M_DQ;

  modport slave (
    input  REQ, OP, ADDR, BIT_SEL, WDATA, M_DQ,
    output BUSY, DONE, ERR, RDATA, M_WE, M_A, M_DI
  );

  modport master (
    output REQ, OP, ADDR, BIT_SEL, WDATA, M_DQ,
    input  BUSY, DONE, ERR, RDATA, M_WE, M_A, M_DI
  );
endinterface

// File: rtl/data_mem_access_unit.sv
// Word/bit load-store initiator for the data memory; bit stores are read-modify-write.
// Latency: word load / bit load DONE at T+3, word store T+2, bit store T+4, out-of-range T+1.
// Backpressure: REQ only sampled while BUSY=0 (IDLE or FIN); REQ while busy is dropped.
// Optional macro DMEM_BIT_TOGGLE_EN: bit store with WDATA[1]=1 inverts the stored bit.
module data_mem_access_unit #(
  parameter int AW    = 16,
  parameter int DW    = 32,
  parameter int BW    = 5,
  parameter int DEPTH = 32
) (
  input  logic                  CLK,
  input  logic                  RST,
  data_mem_access_unit_if.slave bus
);

  localparam logic [1:0] OP_WLD = 2'b00;
  localparam logic [1:0] OP_WST = 2'b01;
  localparam logic [1:0] OP_BLD = 2'b10;
  localparam logic [1:0] OP_BST = 2'b11;

`ifdef DMEM_BIT_TOGGLE_EN
  localparam int WBW = 2;  // WDATA[1] selects toggle, WDATA[0] is the plain bit value
`else
  localparam int WBW = 1;  // only WDATA[0] matters for bit stores
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_RDATA,
    S_WRITE,
    S_FIN
  } state_t;

  state_t         state_q, state_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           err_q, err_d;
  logic [DW-1:0]  rdata_q, rdata_d;
  logic           m_we_q, m_we_d;
  logic [AW-1:0]  m_a_q, m_a_d;
  logic [DW-1:0]  m_di_q, m_di_d;
  logic [1:0]     op_q, op_d;
  logic [BW-1:0]  bit_sel_q, bit_sel_d;
  logic [WBW-1:0] wbit_q, wbit_d;

  logic           old_bit;
  logic           new_bit;
  logic [DW-1:0]  merged_word;

  // Read-modify-write merge: replace the selected bit of the word returned by memory.
  always_comb begin
    old_bit     = bus.M_DQ[bit_sel_q];
`ifdef DMEM_BIT_TOGGLE_EN
    new_bit     = wbit_q[1] ? ~old_bit : wbit_q[0];
`else
    new_bit     = wbit_q[0];
`endif
    merged_word = bus.M_DQ;
    merged_word[bit_sel_q] = new_bit;
  end

  // Next-state and next-output computation; every output leaves the block registered.
  always_comb begin
    state_d   = state_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    rdata_d   = rdata_q;
    m_we_d    = 1'b0;
    m_a_d     = m_a_q;
    m_di_d    = m_di_q;
    op_d      = op_q;
    bit_sel_d = bit_sel_q;
    wbit_d    = wbit_q;

    unique case (state_q)
      // FIN behaves like IDLE for acceptance so operations can run back-to-back.
      S_IDLE, S_FIN: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
        if (bus.REQ) begin
          op_d      = bus.OP;
          bit_sel_d = bus.BIT_SEL;
          wbit_d    = bus.WDATA[WBW-1:0];
          if (bus.ADDR >= AW'(DEPTH)) begin
            // Rejected without touching memory: report straight away.
            state_d = S_FIN;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end else begin
            busy_d = 1'b1;
            m_a_d  = bus.ADDR;
            if (bus.OP == OP_WST) begin
              state_d = S_WRITE;
              m_di_d  = bus.WDATA;
              m_we_d  = 1'b1;
            end else begin
              state_d = S_ISSUE;
            end
          end
        end
      end

      // Memory captures M_A at the end of this cycle.
      S_ISSUE: begin
        state_d = S_RDATA;
      end

      // M_DQ holds the addressed word during this cycle.
      S_RDATA: begin
        if (op_q == OP_BST) begin
          state_d = S_WRITE;
          m_di_d  = merged_word;
          m_we_d  = 1'b1;
        end else begin
          if (op_q == OP_BLD) begin
            rdata_d    = '0;
            rdata_d[0] = old_bit;
          end else begin
            rdata_d = bus.M_DQ;
          end
          state_d = S_FIN;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end
      end

      // Write commits on the edge closing this cycle.
      S_WRITE: begin
        state_d = S_FIN;
        done_d  = 1'b1;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; async reset kills an in-flight write immediately.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= S_IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
      m_we_q    <= 1'b0;
      m_a_q     <= '0;
      m_di_q    <= '0;
      op_q      <= OP_WLD;
      bit_sel_q <= '0;
      wbit_q    <= '0;
    end else begin
      state_q   <= state_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
      m_we_q    <= m_we_d;
      m_a_q     <= m_a_d;
      m_di_q    <= m_di_d;
      op_q      <= op_d;
      bit_sel_q <= bit_sel_d;
      wbit_q    <= wbit_d;
    end
  end

  assign bus.BUSY  = busy_q;
  assign bus.DONE  = done_q;
  assign bus.ERR   = err_q;
  assign bus.RDATA = rdata_q;
  assign bus.M_WE  = m_we_q;
  assign bus.M_A   = m_a_q;
  assign bus.M_DI  = m_di_q;

endmodule

// File: tb/tb_data_mem_access_unit.sv
// Scoreboard bench: requests push expected responses, a negedge monitor pops and compares on DONE.
module tb_data_mem_access_unit;

  logic CLK;
  logic RST;
  int   cyc;
  int   vectors;
  int   miscompares;

  data_mem_access_unit_if #(.AW(16), .DW(32), .BW(5)) bus ();

  data_mem_access_unit #(.AW(16), .DW(32), .BW(5), .DEPTH(32)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  // Memory: address registered on CLK, DQ valid the following cycle, write on CLK when M_WE.
  logic [31:0] mem [0:31];
  logic [15:0] a_reg;
  always @(posedge CLK) begin
    a_reg <= bus.M_A;
    if (bus.M_WE && bus.M_A < 16'd32) mem[bus.M_A[4:0]] <= bus.M_DI;
  end
  assign bus.M_DQ = (a_reg < 16'd32) ? mem[a_reg[4:0]] : 32'hDEAD_BEEF;

  // Reference model state: memory contents and the last load result as the core sees them.
  logic [31:0] ref_mem [0:31];
  logic [31:0] ref_rdata;

  typedef struct {
    int          t0;
    int          lat;
    logic        err;
    logic [31:0] rdata;
    int          we;
  } exp_t;
  exp_t sbq[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: count write strobes between completions and check each DONE against the queue.
  int   we_seen;
  exp_t e;
  always @(negedge CLK) begin
    if (RST) begin
      we_seen = 0;
    end else begin
      if (bus.M_WE) we_seen++;
      if (bus.DONE) begin
        if (sbq.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_done: DONE=1 with no request outstanding (cycle %0d)", cyc);
        end else begin
          e = sbq.pop_front();
          chk("done_latency", 32'(cyc - e.t0), 32'(e.lat));
          chk("err", 32'(bus.ERR), 32'(e.err));
          chk("rdata", bus.RDATA, e.rdata);
          chk("we_pulses", 32'(we_seen), 32'(e.we));
          chk("busy_at_done", 32'(bus.BUSY), 32'd0);
        end
        we_seen = 0;
      end
    end
  end

  // Spec-level model of one accepted request, evaluated in cycle T.
  task automatic model(input logic [1:0] op, input logic [15:0] a, input logic [4:0] bs,
                       input logic [31:0] wd);
    exp_t x;
    logic nb;
    x.t0 = cyc;
    x.err = 1'b0;
    x.we = 0;
    x.lat = 0;
    if (a >= 16'd32) begin
      x.lat = 1;
      x.err = 1'b1;
    end else begin
      case (op)
        2'b00: begin x.lat = 3; ref_rdata = ref_mem[a[4:0]]; end
        2'b01: begin x.lat = 2; x.we = 1; ref_mem[a[4:0]] = wd; end
        2'b10: begin x.lat = 3; ref_rdata = (ref_mem[a[4:0]] >> bs) & 32'd1; end
        default: begin
          x.lat = 4;
          x.we = 1;
`ifdef DMEM_BIT_TOGGLE_EN
          nb = wd[1] ? ~ref_mem[a[4:0]][bs] : wd[0];
`else
          nb = wd[0];
`endif
          ref_mem[a[4:0]][bs] = nb;
        end
      endcase
    end
    x.rdata = ref_rdata;
    sbq.push_back(x);
  endtask

  // Called at posedge+1; waits (with junk REQs that must be ignored) until BUSY=0, then issues.
  task automatic issue(input logic [1:0] op, input logic [15:0] a, input logic [4:0] bs,
                       input logic [31:0] wd, input bit expect_it);
    int g = 0;
    while (bus.BUSY !== 1'b0 && g <= 50) begin
      bus.REQ = 1'b1;
      bus.OP = 2'($urandom);
      bus.ADDR = 16'($urandom_range(0, 39));
      bus.BIT_SEL = 5'($urandom);
      bus.WDATA = $urandom;
      @(posedge CLK); #1;
      g++;
    end
    if (g > 50) begin
      vectors++;
      miscompares++;
      $display("FAIL busy_timeout: BUSY stuck at %0b, expected 0 within 50 cycles", bus.BUSY);
    end
    bus.REQ = 1'b1;
    bus.OP = op;
    bus.ADDR = a;
    bus.BIT_SEL = bs;
    bus.WDATA = wd;
    if (expect_it) model(op, a, bs, wd);
    @(posedge CLK); #1;
    bus.REQ = 1'b0;
    bus.OP = 2'($urandom);
    bus.ADDR = 16'($urandom);
    bus.BIT_SEL = 5'($urandom);
    bus.WDATA = $urandom;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin @(posedge CLK); #1; end
  endtask

  task automatic drain();
    int g = 0;
    while (sbq.size() != 0 && g < 50) begin @(posedge CLK); #1; g++; end
    if (sbq.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain_timeout: %0d responses outstanding, expected 0", sbq.size());
      sbq.delete();
    end
    idle(1);
  endtask

  initial begin
    int g;
    cyc = 0;
    vectors = 0;
    miscompares = 0;
    ref_rdata = 32'd0;
    RST = 1'b1;
    bus.REQ = 1'b0;
    bus.OP = 2'b00;
    bus.ADDR = 16'd0;
    bus.BIT_SEL = 5'd0;
    bus.WDATA = 32'd0;
    for (int i = 0; i < 32; i++) begin
      logic [31:0] v;
      v = $urandom;
      mem[i] <= v;
      ref_mem[i] = v;
    end
    mem[0] <= 32'd200;  ref_mem[0] = 32'd200;
    mem[3] <= 32'd500;  ref_mem[3] = 32'd500;
    mem[9] <= 32'hF5;   ref_mem[9] = 32'hF5;
    mem[11] <= 32'h75;  ref_mem[11] = 32'h75;

    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("reset_busy", 32'(bus.BUSY), 32'd0);
    chk("reset_done", 32'(bus.DONE), 32'd0);
    chk("reset_err", 32'(bus.ERR), 32'd0);
    chk("reset_rdata", bus.RDATA, 32'd0);
    chk("reset_m_we", 32'(bus.M_WE), 32'd0);
    chk("reset_m_a", 32'(bus.M_A), 32'd0);
    chk("reset_m_di", bus.M_DI, 32'd0);
    @(posedge CLK); #1;
    RST = 1'b0;
    idle(2);

    // Word load of a preloaded word.
    issue(2'b00, 16'd3, 5'd0, 32'd0, 1'b1);
    drain();
    // Word store then back-to-back load of the same word.
    issue(2'b01, 16'd7, 5'd9, 32'h1234, 1'b1);
    issue(2'b00, 16'd7, 5'd0, 32'd0, 1'b1);
    drain();
    // Bit store (RMW) then a bit load of a different bit.
    issue(2'b11, 16'd9, 5'd1, 32'd1, 1'b1);
    issue(2'b10, 16'd9, 5'd3, 32'd0, 1'b1);
    drain();
    chk("mem9_after_bit_store", mem[9], 32'hF7);
    // Out of range and the DEPTH boundary on either side.
    issue(2'b00, 16'd40, 5'd0, 32'd0, 1'b1);
    issue(2'b01, 16'd32, 5'd0, 32'hFFFF_FFFF, 1'b1);
    issue(2'b00, 16'd31, 5'd0, 32'd0, 1'b1);
    issue(2'b11, 16'hFFFF, 5'd4, 32'd1, 1'b1);
    drain();

    // Reset during the WRITE state of a bit store: no write, no DONE.
    issue(2'b11, 16'd11, 5'd3, 32'd0, 1'b0);
    g = 0;
    while (bus.M_WE !== 1'b1 && g < 10) begin @(posedge CLK); #1; g++; end
    chk("abort_reached_write", 32'(bus.M_WE), 32'd1);
    RST = 1'b1;
    #1;
    chk("abort_m_we_async", 32'(bus.M_WE), 32'd0);
    chk("abort_busy", 32'(bus.BUSY), 32'd0);
    chk("abort_done", 32'(bus.DONE), 32'd0);
    ref_rdata = 32'd0;
    idle(2);
    chk("abort_mem11_kept", mem[11], 32'h75);
    RST = 1'b0;
    idle(2);

    // Bit store with WDATA=2 on bit 0: 0x74 with or without the toggle feature.
    issue(2'b11, 16'd11, 5'd0, 32'd2, 1'b1);
    issue(2'b00, 16'd11, 5'd0, 32'd0, 1'b1);
    drain();
    chk("mem11_after_wdata2", mem[11], 32'h74);

    // Randomized traffic with random gaps; some out-of-range addresses.
    for (int n = 0; n < 300; n++) begin
      logic [15:0] a;
      logic [31:0] wd;
      a = ($urandom_range(0, 9) == 0) ? 16'($urandom_range(32, 40)) : 16'($urandom_range(0, 31));
      wd = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      issue(2'($urandom), a, 5'($urandom), wd, 1'b1);
      idle($urandom_range(0, 2));
    end
    drain();

    for (int i = 0; i < 32; i++) chk("final_mem", mem[i], ref_mem[i]);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/data_mem_access_unit.md
Name: data_mem_access_unit

Overview:
- Initiator side of the data word memory port: issues word and bit loads/stores from a logic core into the data memory.
- The memory registers its address on CLK; DQ is valid the cycle after the address is captured. Writes complete on the CLK edge where D_WE=1.
- Bit stores are performed as read-modify-write, so the core can execute PLC bit instructions (LD/ST of a single bit) without touching the rest of the word.

Parameters:
- AW, 16, address width (matches memory port)
- DW, 32, data word width
- BW, 5, bit-select width, log2(DW)
- DEPTH, 32, number of implemented memory words; addresses >= DEPTH are rejected

Ports:
- CLK  in  1  system clock, all logic on rising edge
- RST  in  1  asynchronous, active-high reset
- REQ  in  1  core request, sampled only when BUSY=0
- OP  in  2  00 word load, 01 word store, 10 bit load, 11 bit store
- ADDR  in  AW  word address
- BIT_SEL  in  BW  bit index for bit ops
- WDATA  in  DW  store data; bit store uses WDATA[0] (WDATA[1] with optional feature)
- BUSY  out  1  operation in progress
- DONE  out  1  one-cycle completion pulse
- ERR  out  1  valid with DONE; address out of range
- RDATA  out  DW  load result, held until next load completes
- M_WE  out  1  memory write enable (to D_WE)
- M_A  out  AW  memory address (to A)
- M_DI  out  DW  memory write data (to DI)
- M_DQ  in  DW  memory read data (from DQ)

Behaviour:
- Clock and reset: one clock CLK; reset RST is asynchronous and active-high.
- Reset values: BUSY=0, DONE=0, ERR=0, RDATA=0, M_WE=0, M_A=0, M_DI=0, state=IDLE. All outputs are registered.
- Accept: REQ=1 while BUSY=0 in cycle T latches OP, ADDR, BIT_SEL and WDATA. REQ while BUSY=1 is ignored; it is not queued.
- States:
  - IDLE: waiting for an accepted REQ.
  - ISSUE: M_A driven; memory captures it.
  - RDATA: M_DQ valid.
  - WRITE: M_WE=1 for exactly one cycle.
  - FIN: DONE=1, BUSY=0.
- Word load: T -> ISSUE (T+1) -> RDATA (T+2). At end of T+2, RDATA<=M_DQ. FIN: DONE high in T+3.
- Bit load: same timing as word load; RDATA<={(DW-1){0}, M_DQ[BIT_SEL]}. DONE in T+3.
- Word store: T -> WRITE (T+1) with M_A=ADDR, M_DI=WDATA, M_WE=1. FIN: DONE in T+2. RDATA unchanged.
- Bit store: read path as for a load, then WRITE in T+3 with M_DI = M_DQ with bit BIT_SEL replaced by WDATA[0] and M_WE=1. DONE in T+4.
- BUSY: high from T+1 up to, but not including, the FIN cycle. REQ accepted in the FIN cycle starts the next operation back-to-back.
- M_WE is high only in WRITE; it is 0 in every other state.
- Out of range (ADDR >= DEPTH): no memory access, M_WE stays 0. DONE=1 and ERR=1 in T+1; RDATA unchanged.
- ERR is 0 on every in-range DONE.
- Reset mid-operation: M_WE drops immediately (asynchronously) and no write commits; DONE is not issued; state returns to IDLE.
- BIT_SEL is ignored for word ops.

Optional Feature:
- Macro DMEM_BIT_TOGGLE_EN.
- Defined: bit store with WDATA[1]=1 writes the inverse of the read bit, ignoring WDATA[0]. With WDATA[1]=0, behaviour is as in the base design.
- Undefined: WDATA[1] is ignored; bit store always writes WDATA[0].

Test Plan:
- Memory model preloaded with MEM[0]=200, MEM[3]=500; word load ADDR=3 -> DONE in T+3, RDATA=500, ERR=0, M_WE never high.
- Word store ADDR=7, WDATA=0x1234 then word load ADDR=7 back-to-back (REQ in FIN cycle) -> one-cycle M_WE pulse at T+1, second DONE returns RDATA=0x1234.
- MEM[9]=0xF5; bit store ADDR=9, BIT_SEL=1, WDATA[0]=1 -> MEM[9]=0xF7, DONE in T+4; bit load BIT_SEL=3 -> RDATA=0 (0xF7 bit 3 is 0).
- Word load ADDR=40 (>= DEPTH) -> DONE and ERR high in T+1, RDATA holds previous value, M_WE=0.
- Assert RST during the WRITE state of a bit store on ADDR=11 (MEM[11]=0x75) -> M_WE falls at once, MEM[11] remains 0x75, BUSY=0, DONE not seen.
- With DMEM_BIT_TOGGLE_EN defined: bit store ADDR=11, BIT_SEL=0, WDATA=2 -> MEM[11]=0x74. Without the macro, same stimulus -> MEM[11]=0x74, because WDATA[0]=0 is written.
